// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stalls, flushes, forwarding and the data-memory wait/timeout FSM.
// Optional macro FORWARDING_EN enables operand forwarding; without it RAW hazards against E and M are resolved by stalling.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             ResultSrcE,
    input  logic             ResultSrcM,
    input  logic             MemWriteM,
    input  logic             PCSrcE,
    input  logic             MemAck,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemReq,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles
);

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } memState_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    memState_t  memState;
    logic [7:0] waitCnt;
    logic       memopM;
    logic       timeoutHit;
    logic       memStall;
    logic       hazStall;

    assign memopM     = ResultSrcM | MemWriteM;
    assign timeoutHit = (memState == MEM_WAIT) & memopM & ~MemAck & (waitCnt == TIMEOUT_LAST);
    assign memStall   = memopM & ~MemAck & ~timeoutHit;

`ifdef FORWARDING_EN
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs1E)
            ForwardAE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs1E)
            ForwardAE = 2'b01;
        if (RegWriteM && RdM != 5'd0 && RdM == Rs2E)
            ForwardBE = 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == Rs2E)
            ForwardBE = 2'b01;
        if (rst) begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
        end
    end

    assign hazStall = ResultSrcE & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
`else
    logic rawHit1;
    logic rawHit2;
    logic unusedFwd;

    assign ForwardAE = 2'b00;
    assign ForwardBE = 2'b00;

    // W-stage producers need no stall: the register file writes on the opposite edge
    assign rawHit1   = (Rs1D != 5'd0) & ((RegWriteE & (RdE == Rs1D)) | (RegWriteM & (RdM == Rs1D)));
    assign rawHit2   = (Rs2D != 5'd0) & ((RegWriteE & (RdE == Rs2D)) | (RegWriteM & (RdM == Rs2D)));
    assign hazStall  = rawHit1 | rawHit2;
    assign unusedFwd = ^{Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE};
`endif

    // Memory freeze beats a taken branch, which beats a data hazard
    assign StallF = ~rst & (memStall | (~PCSrcE & hazStall));
    assign StallD = ~rst & (memStall | (~PCSrcE & hazStall));
    assign StallE = ~rst & memStall;
    assign StallM = ~rst & memStall;
    assign FlushD = rst | (~memStall & PCSrcE);
    assign FlushE = rst | (~memStall & (PCSrcE | hazStall));
    assign MemReq = ~rst & memopM;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            memState    <= MEM_IDLE;
            waitCnt     <= 8'd0;
            MemErr      <= 1'b0;
            StallCycles <= '0;
        end else begin
            if ((memStall || hazStall) && StallCycles != {CNT_W{1'b1}})
                StallCycles <= StallCycles + CNT_W'(1);
            case (memState)
                MEM_IDLE: begin
                    if (memopM && !MemAck) begin
                        memState <= MEM_WAIT;
                        waitCnt  <= 8'd0;
                    end
                end
                MEM_WAIT: begin
                    if (!memopM || MemAck) begin
                        memState <= MEM_IDLE;
                    end else if (timeoutHit) begin
                        memState <= MEM_IDLE;
                        MemErr   <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                default: memState <= MEM_IDLE;
            endcase
        end
    end

endmodule
